// File: rtl/noc_rank_pkg.sv
// Shared definitions for the Data_Register / Data_Ranking path.
// Holds default port/lane geometry, slot state encoding and lane index helpers.
package noc_rank_pkg;

  localparam int NUM_PORTS = 4;
  localparam int DATA_W    = 8;
  localparam int AGE_W     = 8;

  // Largest representable age; counters stop here instead of wrapping.
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  // Per-slot occupancy state.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_HELD  = 1'b1
  } slot_state_e;

  // Packed-bus geometry shared with Data_Ranking.
  localparam int DATA_BUS_W = NUM_PORTS * DATA_W;
  localparam int AGE_BUS_W  = NUM_PORTS * AGE_W;

  // Low bit of lane 'lane' in a packed bus of 'width'-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/data_age_register_age_slot.sv
// age_slot: one holding slot of data_age_register.
// Keeps a flit plus a saturating age counter; data and age read zero while empty.
module age_slot
  import noc_rank_pkg::*;
#(
  parameter int DATA_W = noc_rank_pkg::DATA_W,
  parameter int AGE_W  = noc_rank_pkg::AGE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rel,
  input  logic [DATA_W-1:0] wr_data,
  output logic              held,
  output logic              held_next,
  output logic [AGE_W-1:0]  age,
  output logic [DATA_W-1:0] data
);

  localparam logic [AGE_W-1:0] AGE_SAT = {AGE_W{1'b1}};

  slot_state_e       state_reg, state_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [AGE_W-1:0]  age_reg, age_next;

  // State, data and age registers; reset discards any held flit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= SLOT_EMPTY;
      data_reg  <= '0;
      age_reg   <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      age_reg   <= age_next;
    end
  end

  // Next state: a write always wins (load or reload), a bare release empties, otherwise age.
  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    age_next   = age_reg;
    case (state_reg)
      SLOT_EMPTY: begin
        if (wr_en) begin
          state_next = SLOT_HELD;
          data_next  = wr_data;
          age_next   = '0;
        end
      end
      SLOT_HELD: begin
        if (wr_en) begin
          data_next = wr_data;
          age_next  = '0;
        end else if (rel) begin
          state_next = SLOT_EMPTY;
          data_next  = '0;
          age_next   = '0;
        end else if (age_reg != AGE_SAT) begin
          age_next = age_reg + 1'b1;
        end
      end
      default: begin
        state_next = SLOT_EMPTY;
        data_next  = '0;
        age_next   = '0;
      end
    endcase
  end

  // Outputs come straight from registers; held_next feeds the occupancy count.
  always_comb begin
    held      = (state_reg == SLOT_HELD);
    held_next = (state_next == SLOT_HELD);
    age       = age_reg;
    data      = data_reg;
  end

endmodule

// File: rtl/data_age_register.sv
// data_age_register: per-port holding register in front of Data_Ranking.
// Packs slot valid/age/data buses, generates in_ready and a registered occupancy.
// Optional starvation alarm is built only when DATA_AGE_STARVE_EN is defined.
module data_age_register
  import noc_rank_pkg::*;
#(
  parameter int NUM_PORTS     = noc_rank_pkg::NUM_PORTS,
  parameter int DATA_W        = noc_rank_pkg::DATA_W,
  parameter int AGE_W         = noc_rank_pkg::AGE_W,
  parameter int STARVE_THRESH = 200
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          in_valid,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
  output logic [NUM_PORTS-1:0]          in_ready,
  input  logic [NUM_PORTS-1:0]          rel_mask,
  output logic [NUM_PORTS-1:0]          input_valid,
  output logic [NUM_PORTS*AGE_W-1:0]    age_of_data,
  output logic [NUM_PORTS*DATA_W-1:0]   input_data,
  output logic [$clog2(NUM_PORTS+1)-1:0] occupancy
`ifdef DATA_AGE_STARVE_EN
  ,
  output logic                          starve_alarm
`endif
);

  localparam int OCC_W = $clog2(NUM_PORTS + 1);

  logic [NUM_PORTS-1:0] wr_en;
  logic [NUM_PORTS-1:0] held_next;
  logic [OCC_W-1:0]     occ_reg, occ_next;

  // A slot accepts when empty or when it is being freed this same cycle.
  always_comb begin
    in_ready = ~input_valid | rel_mask;
    wr_en    = in_valid & in_ready;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_slot
      localparam int DLO = lane_lo(gi, DATA_W);
      localparam int ALO = lane_lo(gi, AGE_W);

      age_slot #(
        .DATA_W (DATA_W),
        .AGE_W  (AGE_W)
      ) u_slot (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en[gi]),
        .rel       (rel_mask[gi]),
        .wr_data   (in_data[DLO +: DATA_W]),
        .held      (input_valid[gi]),
        .held_next (held_next[gi]),
        .age       (age_of_data[ALO +: AGE_W]),
        .data      (input_data[DLO +: DATA_W])
      );
    end
  endgenerate

  // Popcount of the slots that will be held after this edge.
  always_comb begin
    occ_next = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      occ_next = occ_next + OCC_W'(held_next[i]);
    end
  end

  // Occupancy is registered alongside the slot valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_next;
    end
  end

  assign occupancy = occ_reg;

`ifdef DATA_AGE_STARVE_EN
  logic [NUM_PORTS-1:0] starve_hit;
  logic                 starve_reg;

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_starve
      assign starve_hit[gi] = input_valid[gi] &
                              (age_of_data[lane_lo(gi, AGE_W) +: AGE_W] >= AGE_W'(STARVE_THRESH));
    end
  endgenerate

  // Alarm lags the registered ages by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_reg <= 1'b0;
    end else begin
      starve_reg <= |starve_hit;
    end
  end

  assign starve_alarm = starve_reg;
`endif

endmodule
